// File: rtl/red_peak_detector.sv
// Pulse peak detector on the filtered RED stream: hysteresis trough/peak tracking,
// refractory hold-off and no-beat timeout; reports peak amplitude and beat period.
module red_peak_detector #(
  parameter int unsigned DATA_W  = 20,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned HYST    = 2048,
  parameter int unsigned REFRACT = 200,
  parameter int unsigned TIMEOUT = 4000,
  parameter int unsigned WARMUP  = 26
) (
  input  logic              CLK_Filter,
  input  logic              rst,
  input  logic              In_Valid,
  input  logic [DATA_W-1:0] In_RED_Filtered,
  output logic              Peak_Pulse,
  output logic [DATA_W-1:0] Peak_Amplitude,
  output logic [CNT_W-1:0]  Beat_Period,
  output logic              Period_Valid,
  output logic              No_Beat
);

  localparam int unsigned EXT_W = DATA_W + 1;
  localparam int unsigned CP1_W = CNT_W + 1;

  typedef enum logic [1:0] {
    ST_WARMUP   = 2'd0,
    ST_SEEK_MIN = 2'd1,
    ST_RISING   = 2'd2,
    ST_REFRACT  = 2'd3
  } state_e;

  state_e              state_q,    state_d;
  logic [CNT_W-1:0]    warm_cnt_q, warm_cnt_d;
  logic [CNT_W-1:0]    since_q,    since_d;
  logic [CNT_W-1:0]    refr_q,     refr_d;
  logic [DATA_W-1:0]   trough_q,   trough_d;
  logic [DATA_W-1:0]   peak_q,     peak_d;
  logic                has_prev_q, has_prev_d;
  logic                pulse_q,    pulse_d;
  logic [DATA_W-1:0]   amp_q,      amp_d;
  logic [CNT_W-1:0]    period_q,   period_d;
  logic                pvalid_q,   pvalid_d;
  logic                no_beat_q,  no_beat_d;

  // Datapath helpers; sums/differences one bit wider so full-scale samples never wrap
  logic [EXT_W-1:0]  x_ext;
  logic [EXT_W-1:0]  trough_hyst;
  logic [DATA_W-1:0] peak_max;
  logic [DATA_W-1:0] trough_min;
  logic [EXT_W-1:0]  drop;
  logic [CNT_W-1:0]  since_inc;
  logic              timeout_hit;
  logic              warm_last;
  logic              refr_last;

  always_comb begin
    x_ext       = EXT_W'(In_RED_Filtered);
    trough_hyst = EXT_W'(trough_q) + EXT_W'(HYST);
    peak_max    = (In_RED_Filtered > peak_q) ? In_RED_Filtered : peak_q;
    trough_min  = (In_RED_Filtered < trough_q) ? In_RED_Filtered : trough_q;
    drop        = EXT_W'(peak_max) - x_ext;
    since_inc   = (since_q == {CNT_W{1'b1}}) ? since_q : since_q + CNT_W'(1);
    timeout_hit = (CP1_W'(since_q) + CP1_W'(1)) >= CP1_W'(TIMEOUT);
    warm_last   = (warm_cnt_q == CNT_W'(WARMUP - 1));
    refr_last   = (refr_q == CNT_W'(REFRACT - 1));
  end

  // Next-state and output decode; everything holds on invalid samples
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    since_d    = since_q;
    refr_d     = refr_q;
    trough_d   = trough_q;
    peak_d     = peak_q;
    has_prev_d = has_prev_q;
    pulse_d    = 1'b0;
    amp_d      = amp_q;
    period_d   = period_q;
    pvalid_d   = 1'b0;
    no_beat_d  = no_beat_q;

    if (In_Valid) begin
      unique case (state_q)
        ST_WARMUP: begin
          if (warm_last) begin
            state_d  = ST_SEEK_MIN;
            trough_d = In_RED_Filtered;
            since_d  = '0;
          end else begin
            warm_cnt_d = warm_cnt_q + CNT_W'(1);
          end
        end
        ST_SEEK_MIN, ST_RISING: begin
          since_d = since_inc;
          if (timeout_hit) begin
            // Timeout wins over a same-sample confirmation
            no_beat_d  = 1'b1;
            has_prev_d = 1'b0;
            since_d    = '0;
            trough_d   = In_RED_Filtered;
            state_d    = ST_SEEK_MIN;
          end else if (state_q == ST_SEEK_MIN) begin
            trough_d = trough_min;
            if (x_ext >= trough_hyst) begin
              state_d = ST_RISING;
              peak_d  = In_RED_Filtered;
            end
          end else begin
            peak_d = peak_max;
            if (drop >= EXT_W'(HYST)) begin
              pulse_d   = 1'b1;
              amp_d     = peak_q - trough_q;
              no_beat_d = 1'b0;
              if (has_prev_q) begin
                period_d = since_inc;
                pvalid_d = 1'b1;
              end
              has_prev_d = 1'b1;
              since_d    = '0;
              refr_d     = '0;
              trough_d   = In_RED_Filtered;
              state_d    = ST_REFRACT;
            end
          end
        end
        ST_REFRACT: begin
          since_d  = since_inc;
          trough_d = trough_min;
          refr_d   = refr_q + CNT_W'(1);
          if (refr_last) state_d = ST_SEEK_MIN;
        end
        default: state_d = ST_WARMUP;
      endcase
    end
  end

  always_ff @(posedge CLK_Filter or posedge rst) begin
    if (rst) begin
      state_q    <= ST_WARMUP;
      warm_cnt_q <= '0;
      since_q    <= '0;
      refr_q     <= '0;
      trough_q   <= '0;
      peak_q     <= '0;
      has_prev_q <= 1'b0;
      pulse_q    <= 1'b0;
      amp_q      <= '0;
      period_q   <= '0;
      pvalid_q   <= 1'b0;
      no_beat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      since_q    <= since_d;
      refr_q     <= refr_d;
      trough_q   <= trough_d;
      peak_q     <= peak_d;
      has_prev_q <= has_prev_d;
      pulse_q    <= pulse_d;
      amp_q      <= amp_d;
      period_q   <= period_d;
      pvalid_q   <= pvalid_d;
      no_beat_q  <= no_beat_d;
    end
  end

  assign Peak_Pulse     = pulse_q;
  assign Peak_Amplitude = amp_q;
  assign Beat_Period    = period_q;
  assign Period_Valid   = pvalid_q;
  assign No_Beat        = no_beat_q;

endmodule
